sample_source: RTL

- Parametrised successor of the fixed 10-bit ADC/test-pattern data generator.
- Sits in the ADC clock domain, between the ADC databus pins and the write side of the capture FIFO.
- Produces one OUT_WIDTH-bit word per clock. Source is selectable among raw ADC, ADC tagged with a sequence number, and two test-counter patterns.
- Mode comes from the FX3 configuration bits and is resynchronised internally.

---
 rtl/sample_source_pkg.sv | 20 ++
 rtl/sync2.sv | 24 ++
 rtl/sample_source.sv | 113 +++++++++++
 3 files changed

// File: rtl/sample_source_pkg.sv
// Shared definitions for the ADC / test-pattern sample source.
// Mode encodings follow the FX3 configuration bits.
package sample_source_pkg;

    typedef enum logic [1:0] {
        MODE_ADC      = 2'b00,
        MODE_ADC_SEQ  = 2'b01,
        MODE_TEST     = 2'b10,
        MODE_TEST_SEQ = 2'b11
    } mode_e;

    localparam int ADC_WIDTH_DEF = 10;
    localparam int OUT_WIDTH_DEF = 16;
    localparam int SEQ_BITS      = OUT_WIDTH_DEF - ADC_WIDTH_DEF;

    function automatic int seq_bits(input int out_w, input int adc_w);
        return out_w - adc_w;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous FX3 configuration bits.
// Both stages clear to zero on reset.
module sync2 #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sample_source.sv
// ADC / test-pattern sample source feeding the capture FIFO.
// Two-stage pipeline with optional sequence-number tagging.
module sample_source
    import sample_source_pkg::*;
#(
    parameter int ADC_WIDTH = 10,
    parameter int OUT_WIDTH = 16,
    parameter int TEST_MAX  = 1020,
    parameter int SEQ_DIV   = 65536
) (
    input  logic                           clock,
    input  logic                           nReset,
    input  logic [ADC_WIDTH-1:0]           adc_databus,
    input  logic                           enable,
    input  logic [1:0]                     modeIn,
    output logic [OUT_WIDTH-1:0]           dataOut,
    output logic                           dataValid,
    output logic [OUT_WIDTH-ADC_WIDTH-1:0] seqNumber
);

    localparam int SW    = seq_bits(OUT_WIDTH, ADC_WIDTH);
    localparam int DIV_W = $clog2(SEQ_DIV);

    localparam logic [ADC_WIDTH-1:0] T_MAX = ADC_WIDTH'(TEST_MAX);
    localparam logic [DIV_W-1:0]     D_MAX = DIV_W'(SEQ_DIV - 1);

    logic [1:0]           mode_sync;
    mode_e                cur_mode;
    logic                 mode_change;
    logic                 is_test;
    logic                 is_seq;

    logic [ADC_WIDTH-1:0] test_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [SW-1:0]        seq_cnt;

    logic                 s1_valid;
    logic [ADC_WIDTH-1:0] s1_sample;
    logic [SW-1:0]        s1_seq;

    sync2 #(
        .WIDTH (2)
    ) u_mode_sync (
        .clock  (clock),
        .nReset (nReset),
        .d      (modeIn),
        .q      (mode_sync)
    );

    assign mode_change = (mode_sync != cur_mode);
    assign is_test     = (cur_mode == MODE_TEST) ||
                         (cur_mode == MODE_TEST_SEQ);
    assign is_seq      = (cur_mode == MODE_ADC_SEQ) ||
                         (cur_mode == MODE_TEST_SEQ);
    assign seqNumber   = seq_cnt;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            cur_mode <= MODE_ADC;
        end else if (mode_change) begin
            cur_mode <= mode_e'(mode_sync);
        end
    end

    // A mode change restarts all counters, overriding any increment.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            test_cnt <= '0;
            div_cnt  <= '0;
            seq_cnt  <= '0;
        end else if (mode_change) begin
            test_cnt <= '0;
            div_cnt  <= '0;
            seq_cnt  <= '0;
        end else if (enable) begin
            if (test_cnt == T_MAX) test_cnt <= '0;
            else                   test_cnt <= test_cnt + 1'b1;
            if (div_cnt == D_MAX) begin
                div_cnt <= '0;
                seq_cnt <= seq_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Stage 1 captures the tag with the sample, so in-flight words
    // keep their old-mode format across a mode change.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_seq    <= '0;
        end else begin
            s1_valid <= enable;
            if (enable) begin
                s1_sample <= is_test ? test_cnt : adc_databus;
                s1_seq    <= is_seq ? seq_cnt : '0;
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            dataValid <= 1'b0;
            dataOut   <= '0;
        end else begin
            dataValid <= s1_valid;
            if (s1_valid) dataOut <= {s1_seq, s1_sample};
        end
    end

endmodule
